fir_mac_dbuf_filter: RTL
========================

Name: fir_mac_dbuf_filter

Overview:
Parametrised, time-multiplexed single-MAC FIR filter and the next generation of the 4-bank SPSRAM FIR.
- Tap count, coefficient width, input width and output width are parameters.
- Coefficients live in two internal sets (active/shadow). The host rewrites the shadow set while filtering continues, then swaps sets on a sample boundary. No filter stop or update phase is needed.
- Sits between the 4-PAM symbol source (one sample per 600 kHz enable) and the DAC/output path.

Parameters:
NUM_TAPS, 33, filter length (2..64)
IN_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
OUT_W, 16, signed saturated output width
ADDR_W, 6, coefficient address width; must satisfy 2**ADDR_W >= NUM_TAPS
ACC_W, IN_W+COEF_W+7, accumulator width (derived; never overflows for NUM_TAPS<=64 after sign extension)

Ports:
iClk12M  in  1  system clock (12 MHz)
iRsn  in  1  reset, asynchronous, active-low
iEnSample  in  1  one-clock sample strobe (600 kHz)
iFirIn  in  IN_W  signed input sample
iCsnCoef  in  1  coefficient port select, active-low
iWrnCoef  in  1  coefficient write enable, active-low
iAddrCoef  in  ADDR_W  tap index 0..NUM_TAPS-1
iWrDtCoef  in  COEF_W  signed coefficient data
iCoeffSwap  in  1  one-clock swap request
oActiveSet  out  1  index of the active coefficient set
oSwapPending  out  1  swap requested, not yet committed
oFirOut  out  OUT_W  signed filtered output, held between updates
oFirValid  out  1  one-clock pulse when oFirOut updates
oSat  out  1  sticky; set when any output saturated
oOverrun  out  1  sticky; set when iEnSample arrived while busy

Behaviour:
- Reset (async, iRsn=0): all outputs 0; delay line 0; both coefficient sets 0; FSM IDLE; active set 0.
- Coefficient write:
  - When iCsnCoef=0 and iWrnCoef=0 at a rising edge, iWrDtCoef is written to shadow[iAddrCoef].
  - Addresses >= NUM_TAPS are ignored.
  - The active set is never writable.
  - Writes are legal in any FSM state.
- Swap:
  - iCoeffSwap sets oSwapPending.
  - Commit happens on the edge where IDLE accepts iEnSample: oActiveSet toggles, oSwapPending clears, and the sample is computed with the new set.
  - If a coefficient write occurs on that same edge, the commit defers to the next accepted sample and the write lands in the old shadow.
  - A swap request while already pending has no effect.
- FSM IDLE -> MAC -> OUT -> IDLE:
  - IDLE: on iEnSample, shift the delay line (x[0] <= iFirIn, x[k] <= x[k-1]), clear acc, set idx=0, go to MAC.
  - MAC: acc += sext(x[idx]) * c_active[idx] each clock, idx++; after idx = NUM_TAPS-1, go to OUT.
  - OUT: oFirOut <= sat(acc), oFirValid=1 for one clock, go to IDLE.
- Latency: iEnSample sampled at edge E0 -> oFirOut/oFirValid registered at edge E(NUM_TAPS+1); 34 clocks for 33 taps.
- The sample period must be >= NUM_TAPS+2 clocks (the 20-clock 600 kHz strobe only supports NUM_TAPS <= 18 at 12 MHz).
- iEnSample outside IDLE: the sample is dropped, oOverrun is set, and the running computation is unaffected.
- Saturation:
  - acc > 2**(OUT_W-1)-1 gives max; acc < -2**(OUT_W-1) gives min; either case sets oSat.
  - Otherwise the output is the low OUT_W bits, with no scaling or rounding.
- oSat and oOverrun clear only on reset.

Decomposition:
- Package fir_mac_pkg holds:
  - FSM state encoding (IDLE/MAC/OUT)
  - clog2 function
  - saturation function (ACC_W -> OUT_W)
- Sub-module fir_coef_bank holds:
  - the two-set coefficient register file, with write port to the shadow set
  - the combinational read port on the active set by idx
  - swap/pending/defer logic and the oActiveSet/oSwapPending outputs
- The top level holds the delay line, the MAC and the FSM.

Test Plan:
- Impulse: NUM_TAPS=33, a 40-clock sample period, coefficients loaded, then swap; impulse +1 (3'b001) then zeros -> oFirOut sequence 3,0,-6,7,0,-11,...,206,500,206,...,3 then 0; each oFirValid arrives 34 clocks after its strobe.
- Scaling and sign: impulses +3 (3'b011), -1 (3'b111), -3 (3'b101) -> 3x, -1x, -3x the coefficient sequence; the peak is 1500, -500, -1500 respectively.
- Live update: while filtering, write a shadow set with center tap 1000, then pulse iCoeffSwap -> outputs keep using the old set until the next accepted sample; oActiveSet toggles; a subsequent +1 impulse peaks at 1000.
- Swap-write collision: assert a coefficient write on the commit edge -> the swap defers one sample and oSwapPending stays 1 through that sample.
- Saturation: all taps 32767, constant +3 input -> oFirOut=32767 and oSat=1; all taps 32767, constant -4 (3'b100) -> oFirOut=-32768.
- Overrun and reset: strobe every 10 clocks -> oOverrun=1 and only accepted samples produce oFirValid; assert iRsn=0 mid-MAC -> all outputs 0 immediately and oActiveSet=0.

Source files
------------

// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the single-MAC double-buffered FIR filter.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Classifies a sign-extended accumulator against the signed out_w-bit range.
  function automatic sat_e sat_class(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (acc > max_v) return SAT_POS;
    if (acc < min_v) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Two-set coefficient register file: host writes the shadow set, the MAC reads
// the active set, and a pending swap commits on the next accepted sample.
module fir_coef_bank
  import fir_mac_pkg::*;
#(
  parameter int NUM_TAPS = 33,
  parameter int COEF_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int IDX_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     swap_req,
  input  logic                     accept,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic signed [COEF_W-1:0] rd_data,
  output logic                     active_set,
  output logic                     swap_pending
);

  logic signed [COEF_W-1:0] coef_q [2][NUM_TAPS];
  logic signed [COEF_W-1:0] coef_d [2][NUM_TAPS];
  logic act_q, act_d;
  logic pend_q, pend_d;
  logic commit;

  // A write on the accept edge keeps the old shadow stable, so the commit waits.
  always_comb begin
    coef_d = coef_q;
    commit = accept && pend_q && !wr_req;
    act_d  = act_q ^ commit;
    pend_d = commit ? 1'b0 : (pend_q | swap_req);
    if (wr_req && (int'(wr_addr) < NUM_TAPS)) begin
      coef_d[~act_q][wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          coef_q[s][t] <= '0;
        end
      end
      act_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      coef_q <= coef_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

  assign rd_data      = coef_q[act_q][rd_idx];
  assign active_set   = act_q;
  assign swap_pending = pend_q;

endmodule

// File: rtl/fir_mac_dbuf_filter.sv
// Time-multiplexed single-MAC FIR: one tap per clock over a delay line, with a
// saturated output register and sticky saturation/overrun flags.
module fir_mac_dbuf_filter
  import fir_mac_pkg::*;
#(
  parameter int NUM_TAPS = 33,
  parameter int IN_W     = 3,
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 16,
  parameter int ADDR_W   = 6,
  parameter int ACC_W    = IN_W + COEF_W + 7
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample,
  input  logic signed [IN_W-1:0]   iFirIn,
  input  logic                     iCsnCoef,
  input  logic                     iWrnCoef,
  input  logic [ADDR_W-1:0]        iAddrCoef,
  input  logic signed [COEF_W-1:0] iWrDtCoef,
  input  logic                     iCoeffSwap,
  output logic                     oActiveSet,
  output logic                     oSwapPending,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oFirValid,
  output logic                     oSat,
  output logic                     oOverrun
);

  localparam int IDX_W  = clog2(NUM_TAPS);
  localparam int PROD_W = IN_W + COEF_W;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  fir_state_e state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [IN_W-1:0]   x_q [NUM_TAPS];
  logic signed [IN_W-1:0]   x_d [NUM_TAPS];
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic vld_q, vld_d;
  logic sat_q, sat_d;
  logic ovr_q, ovr_d;
  logic accept;
  logic wr_req;
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       acc_ext;
  sat_e                     sat_kind;

  assign wr_req = !iCsnCoef && !iWrnCoef;
  assign accept = (state_q == ST_IDLE) && iEnSample;

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_coef_bank (
    .clk          (iClk12M),
    .rst_n        (iRsn),
    .wr_req       (wr_req),
    .wr_addr      (iAddrCoef),
    .wr_data      (iWrDtCoef),
    .swap_req     (iCoeffSwap),
    .accept       (accept),
    .rd_idx       (idx_q),
    .rd_data      (coef_rd),
    .active_set   (oActiveSet),
    .swap_pending (oSwapPending)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    out_d    = out_q;
    vld_d    = 1'b0;
    sat_d    = sat_q;
    ovr_d    = ovr_q | (iEnSample && (state_q != ST_IDLE));
    prod     = PROD_W'(x_q[idx_q]) * PROD_W'(coef_rd);
    acc_ext  = 64'(acc_q);
    sat_kind = sat_class(acc_ext, OUT_W);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d[0] = iFirIn;
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == IDX_W'(NUM_TAPS - 1)) begin
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_OUT: begin
        vld_d   = 1'b1;
        state_d = ST_IDLE;
        case (sat_kind)
          SAT_POS: begin
            out_d = OUT_MAX;
            sat_d = 1'b1;
          end
          SAT_NEG: begin
            out_d = OUT_MIN;
            sat_d = 1'b1;
          end
          default: out_d = acc_q[OUT_W-1:0];
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
      end
      out_q   <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oFirOut   = out_q;
  assign oFirValid = vld_q;
  assign oSat      = sat_q;
  assign oOverrun  = ovr_q;

endmodule
